// File: rtl/botoes_jogada.sv
// botoes_jogada: turns debounced button levels into single play events.
// Arms only once every button is released, accepts one press at a time
// (the lowest index wins), measures how long it is held, and flags extra
// presses that arrive at acceptance or during the hold.
module botoes_jogada #(
  parameter int unsigned N_BOTOES  = 13,
  parameter int unsigned DUR_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_BOTOES-1:0]  botoes_debounced,
  output logic                 jogada_feita,
  output logic [3:0]           nota,
  output logic                 nota_valida,
  output logic [DUR_WIDTH-1:0] duracao,
  output logic                 soltou,
  output logic                 erro_multipla
);

  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ESPERA_LIBERAR = 2'd0,
    OCIOSO         = 2'd1,
    PRESSIONADO    = 2'd2
  } estado_t;

  estado_t              r_estado;
  estado_t              w_prox_estado;

  logic [N_BOTOES-1:0]  r_prev;

  logic                 r_jogada_feita;
  logic [IDX_W-1:0]     r_nota;
  logic                 r_nota_valida;
  logic [DUR_WIDTH-1:0] r_duracao;
  logic                 r_soltou;
  logic                 r_erro_multipla;

  logic                 w_jogada_feita;
  logic [IDX_W-1:0]     w_nota;
  logic                 w_nota_valida;
  logic [DUR_WIDTH-1:0] w_duracao;
  logic                 w_soltou;
  logic                 w_erro_multipla;

  logic                 w_algum;
  logic                 w_multiplos;
  logic [IDX_W-1:0]     w_menor_idx;
  logic                 w_nota_presa;
  logic [N_BOTOES-1:0]  w_mascara_nota;
  logic [N_BOTOES-1:0]  w_subida_outros;
  logic [DUR_WIDTH-1:0] w_duracao_inc;

  // Any press, and more than one press at once (clearing the lowest bit leaves something)
  assign w_algum     = |botoes_debounced;
  assign w_multiplos = |(botoes_debounced & (botoes_debounced - N_BOTOES'(1)));

  // Priority encoder: the lowest set index wins
  always_comb begin
    w_menor_idx = '0;
    for (int i = int'(N_BOTOES) - 1; i >= 0; i--) begin
      if (botoes_debounced[i]) begin
        w_menor_idx = IDX_W'(i);
      end
    end
  end

  // One-hot mask of the captured note and whether that button is still down
  always_comb begin
    w_mascara_nota = '0;
    w_nota_presa   = 1'b0;
    for (int i = 0; i < int'(N_BOTOES); i++) begin
      if (r_nota == IDX_W'(i)) begin
        w_mascara_nota[i] = 1'b1;
        w_nota_presa      = botoes_debounced[i];
      end
    end
  end

  // Rising edges on buttons other than the one being held
  assign w_subida_outros = botoes_debounced & ~r_prev & ~w_mascara_nota;

  // Hold counter sticks at all-ones instead of wrapping
  assign w_duracao_inc = (r_duracao == {DUR_WIDTH{1'b1}}) ? r_duracao
                                                          : r_duracao + DUR_WIDTH'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= ESPERA_LIBERAR;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state logic
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      ESPERA_LIBERAR: begin
        if (!w_algum) begin
          w_prox_estado = OCIOSO;
        end
      end
      OCIOSO: begin
        if (w_algum) begin
          w_prox_estado = enable ? PRESSIONADO : ESPERA_LIBERAR;
        end
      end
      PRESSIONADO: begin
        if (!w_nota_presa) begin
          w_prox_estado = w_algum ? ESPERA_LIBERAR : OCIOSO;
        end
      end
      default: w_prox_estado = ESPERA_LIBERAR;
    endcase
  end

  // Next output values; pulses default low, held values default to their current value
  always_comb begin
    w_jogada_feita  = 1'b0;
    w_soltou        = 1'b0;
    w_erro_multipla = 1'b0;
    w_nota          = r_nota;
    w_nota_valida   = r_nota_valida;
    w_duracao       = r_duracao;
    case (r_estado)
      OCIOSO: begin
        if (enable && w_algum) begin
          w_jogada_feita  = 1'b1;
          w_nota          = w_menor_idx;
          w_nota_valida   = 1'b1;
          w_duracao       = DUR_WIDTH'(1);
          w_erro_multipla = w_multiplos;
        end
      end
      PRESSIONADO: begin
        if (w_nota_presa) begin
          w_duracao       = w_duracao_inc;
          w_erro_multipla = |w_subida_outros;
        end else begin
          w_nota_valida = 1'b0;
          w_soltou      = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and edge-history registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev          <= '0;
      r_jogada_feita  <= 1'b0;
      r_nota          <= '0;
      r_nota_valida   <= 1'b0;
      r_duracao       <= '0;
      r_soltou        <= 1'b0;
      r_erro_multipla <= 1'b0;
    end else begin
      r_prev          <= botoes_debounced;
      r_jogada_feita  <= w_jogada_feita;
      r_nota          <= w_nota;
      r_nota_valida   <= w_nota_valida;
      r_duracao       <= w_duracao;
      r_soltou        <= w_soltou;
      r_erro_multipla <= w_erro_multipla;
    end
  end

  assign jogada_feita  = r_jogada_feita;
  assign nota          = r_nota;
  assign nota_valida   = r_nota_valida;
  assign duracao       = r_duracao;
  assign soltou        = r_soltou;
  assign erro_multipla = r_erro_multipla;

endmodule

// File: tb/tb_botoes_jogada.sv
// Bench for botoes_jogada: two instances (16-bit and 4-bit hold counter)
// share one stimulus stream and are checked every cycle against a
// behavioural model, plus literal checks on the directed scenarios.
module tb_botoes_jogada;

  localparam int unsigned NB = 13;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [NB-1:0] botoes = '0;

  logic          jog_a, val_a, solt_a, err_a;
  logic [3:0]    nota_a;
  logic [15:0]   dur_a;
  logic          jog_b, val_b, solt_b, err_b;
  logic [3:0]    nota_b;
  logic [3:0]    dur_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_jog_a  = 0;

  always #5 clock = ~clock;

  botoes_jogada #(.N_BOTOES(NB), .DUR_WIDTH(16)) u_main (
    .clock(clock), .reset(reset), .enable(enable), .botoes_debounced(botoes),
    .jogada_feita(jog_a), .nota(nota_a), .nota_valida(val_a), .duracao(dur_a),
    .soltou(solt_a), .erro_multipla(err_a)
  );

  botoes_jogada #(.N_BOTOES(NB), .DUR_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .botoes_debounced(botoes),
    .jogada_feita(jog_b), .nota(nota_b), .nota_valida(val_b), .duracao(dur_b),
    .soltou(solt_b), .erro_multipla(err_b)
  );

  // Behavioural model: "holding" a captured note, or "armed" waiting for a press
  typedef struct {
    bit            holding;
    bit            armed;
    logic [NB-1:0] prev;
    bit            jog;
    bit            solt;
    bit            err;
    bit            val;
    int            nota;
    int unsigned   dur;
  } mdl_t;

  mdl_t m_a, m_b;

  function automatic mdl_t step(mdl_t s, logic [NB-1:0] b, bit en, bit rst, int unsigned maxd);
    mdl_t n;
    logic [NB-1:0] rise;
    n = s;
    n.jog  = 0;
    n.solt = 0;
    n.err  = 0;
    if (rst) begin
      n.holding = 0; n.armed = 0; n.prev = '0;
      n.val = 0; n.nota = 0; n.dur = 0;
      return n;
    end
    if (s.holding) begin
      if (b[s.nota]) begin
        if (s.dur < maxd) n.dur = s.dur + 1;
        rise = b & ~s.prev;
        rise[s.nota] = 1'b0;
        n.err = (rise != '0);
      end else begin
        n.val = 0; n.solt = 1; n.holding = 0;
        n.armed = (b == '0);
      end
    end else if (!s.armed) begin
      if (b == '0) n.armed = 1;
    end else if (b != '0) begin
      if (en) begin
        for (int i = NB - 1; i >= 0; i--) if (b[i]) n.nota = i;
        n.val = 1; n.dur = 1; n.jog = 1; n.holding = 1;
        n.err = ($countones(b) > 1);
      end else begin
        n.armed = 0;
      end
    end
    n.prev = b;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};
    forever begin
      @(posedge clock);
      m_a = step(m_a, botoes, enable, reset, 32'd65535);
      m_b = step(m_b, botoes, enable, reset, 32'd15);
      #1;
      if (jog_a) n_jog_a++;
      chk("a.jogada_feita",  int'(jog_a),  int'(m_a.jog));
      chk("a.nota",          int'(nota_a), m_a.nota);
      chk("a.nota_valida",   int'(val_a),  int'(m_a.val));
      chk("a.duracao",       int'(dur_a),  int'(m_a.dur));
      chk("a.soltou",        int'(solt_a), int'(m_a.solt));
      chk("a.erro_multipla", int'(err_a),  int'(m_a.err));
      chk("b.jogada_feita",  int'(jog_b),  int'(m_b.jog));
      chk("b.nota",          int'(nota_b), m_b.nota);
      chk("b.nota_valida",   int'(val_b),  int'(m_b.val));
      chk("b.duracao",       int'(dur_b),  int'(m_b.dur));
      chk("b.soltou",        int'(solt_b), int'(m_b.solt));
      chk("b.erro_multipla", int'(err_b),  int'(m_b.err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int snap;
    int r;

    // Reset while bit 3 is held: outputs clear, no acceptance until released
    botoes = NB'(1) << 3;
    cyc(2);
    chk("rst_valida", int'(val_a), 0);
    chk("rst_dur",    int'(dur_a), 0);
    chk("rst_nota",   int'(nota_a), 0);
    reset = 1'b0;
    snap = n_jog_a;
    cyc(10);
    chk("held_from_reset_jog", n_jog_a - snap, 0);
    botoes = '0;
    cyc(2);
    botoes = NB'(1) << 3;
    cyc(1);
    chk("b3_jog",    int'(jog_a), 1);
    chk("b3_nota",   int'(nota_a), 3);
    chk("b3_valida", int'(val_a), 1);
    cyc(1);
    chk("b3_jog_pulse", int'(jog_a), 0);
    botoes = '0;
    cyc(1);
    chk("b3_soltou", int'(solt_a), 1);
    cyc(1);

    // Bit 5 held 20 cycles
    snap = n_jog_a;
    botoes = NB'(1) << 5;
    cyc(20);
    chk("b5_one_jog", n_jog_a - snap, 1);
    botoes = '0;
    cyc(1);
    chk("b5_soltou",  int'(solt_a), 1);
    chk("b5_dur",     int'(dur_a), 20);
    chk("b5_valida",  int'(val_a), 0);
    chk("b5_nota",    int'(nota_a), 5);
    chk("b5_dur_sat", int'(dur_b), 15);
    chk("b5_model_dur", int'(m_a.dur), 20);

    // Simultaneous bits 4 and 7
    botoes = 13'b0_0000_1001_0000;
    cyc(1);
    chk("sim_nota", int'(nota_a), 4);
    chk("sim_jog",  int'(jog_a), 1);
    chk("sim_err",  int'(err_a), 1);
    botoes = '0;
    cyc(2);

    // Bit 2 held, bit 9 rises at cycle 5, bit 2 releases after cycle 8
    botoes = NB'(1) << 2;
    cyc(4);
    chk("hold_err_before", int'(err_a), 0);
    botoes = botoes | (NB'(1) << 9);
    cyc(1);
    chk("hold_err_at5", int'(err_a), 1);
    chk("hold_nota",    int'(nota_a), 2);
    cyc(1);
    chk("hold_err_once", int'(err_a), 0);
    cyc(2);
    botoes = NB'(1) << 9;
    cyc(1);
    chk("hold_soltou", int'(solt_a), 1);
    chk("hold_dur",    int'(dur_a), 8);
    chk("hold_err_rel", int'(err_a), 0);
    snap = n_jog_a;
    cyc(5);
    chk("b9_no_jog", n_jog_a - snap, 0);
    botoes = '0;
    cyc(2);

    // Long hold of bit 0: narrow counter saturates
    botoes = NB'(1);
    cyc(30);
    botoes = '0;
    cyc(1);
    chk("sat_soltou",  int'(solt_b), 1);
    chk("sat_dur_b",   int'(dur_b), 15);
    chk("sat_dur_a",   int'(dur_a), 30);
    cyc(1);

    // Press while disabled, enable rises during the hold: never accepted
    enable = 1'b0;
    snap = n_jog_a;
    botoes = NB'(1) << 1;
    cyc(1);
    enable = 1'b1;
    cyc(5);
    chk("dis_no_jog", n_jog_a - snap, 0);
    botoes = '0;
    cyc(2);

    // Reset during a hold: outputs clear, no release pulse afterwards
    botoes = NB'(1) << 6;
    cyc(4);
    chk("b6_valida", int'(val_a), 1);
    reset = 1'b1;
    cyc(1);
    chk("midrst_valida", int'(val_a), 0);
    chk("midrst_dur",    int'(dur_a), 0);
    chk("midrst_soltou", int'(solt_a), 0);
    reset = 1'b0;
    cyc(2);
    botoes = '0;
    cyc(1);
    chk("midrst_no_soltou", int'(solt_a), 0);
    cyc(1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
      end else if (r < 80) begin
        botoes[$urandom_range(0, NB - 1)] ^= 1'b1;
      end else if (r < 93) begin
        botoes = '0;
      end else begin
        botoes = NB'($urandom);
      end
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 199) == 0);
      cyc(1);
    end

    reset = 1'b0;
    botoes = '0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
